inst_mem: RTL and testbench

Instruction memory for the Naive CPU: the responder on the CPU's instruction-fetch port (`rom_ce`/`rom_addr`/`rom_data`). It also contains a byte-stream loader that fills the memory from a host link. While loading it asserts a hold so the system keeps the CPU in reset. Reads are combinational, matching the CPU's registered-PC / registered-IR fetch pipeline. Writes come only from the loader.

---
 rtl/naive_pkg.sv | 17 +
 rtl/defines.sv | 10 +
 rtl/word_packer.sv | 53 +++++
 rtl/inst_mem.sv | 114 +++++++++++
 tb/tb_inst_mem.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/naive_pkg.sv
// Shared Naive CPU types.
// Loader FSM state encodings for the instruction memory.
`include "defines.sv"

package naive_pkg;

  localparam logic [1:0] LdIdle = 2'd0;
  localparam logic [1:0] LdLoad = 2'd1;
  localparam logic [1:0] LdDone = 2'd2;

  typedef enum logic [1:0] {
    LD_IDLE = LdIdle,
    LD_LOAD = LdLoad,
    LD_DONE = LdDone
  } ld_state_t;

endpackage

// File: rtl/defines.sv
// Naive CPU global width macros.
// Included by every RTL file that needs bus widths.
`ifndef NAIVE_DEFINES_SV
`define NAIVE_DEFINES_SV

`define RegBus 31:0
`define InstBus 31:0
`define InstMemAddrW 10

`endif

// File: rtl/word_packer.sv
// Big-endian byte-to-word packer for the image loader.
// Emits a word on the 4th byte or on a last byte (zero-padded).
`include "defines.sv"

module word_packer
  import naive_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            in_valid,
  input  logic [7:0]      in_byte,
  input  logic            in_last,
  output logic            word_valid,
  output logic [`InstBus] word
);

  logic [1:0]      cnt;
  logic [`InstBus] acc;

  // acc holds earlier bytes only, so low bytes are already zero for padding
  always_comb begin
    word = acc;
    unique case (cnt)
      2'd0: word[31:24] = in_byte;
      2'd1: word[23:16] = in_byte;
      2'd2: word[15:8]  = in_byte;
      2'd3: word[7:0]   = in_byte;
      default: word = acc;
    endcase
  end

  assign word_valid = in_valid & ((cnt == 2'd3) | in_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 2'd0;
      acc <= '0;
    end else if (clear) begin
      cnt <= 2'd0;
      acc <= '0;
    end else if (in_valid) begin
      if (word_valid) begin
        cnt <= 2'd0;
        acc <= '0;
      end else begin
        cnt <= cnt + 2'd1;
        acc <= word;
      end
    end
  end

endmodule

// File: rtl/inst_mem.sv
// Naive CPU instruction memory with combinational fetch
// and a host byte-stream loader that holds the CPU in reset.
`include "defines.sv"

module inst_mem
  import naive_pkg::*;
#(
  parameter int ADDR_W = `InstMemAddrW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rom_ce_i,
  input  logic [31:0]     rom_addr_i,
  output logic [`InstBus] rom_data_o,
  input  logic            ld_start_i,
  input  logic            ld_valid_i,
  input  logic [7:0]      ld_byte_i,
  input  logic            ld_last_i,
  output logic            ld_ready_o,
  output logic            cpu_hold_o,
  output logic            ld_done_o,
  output logic            ld_err_o,
  output logic [ADDR_W:0] ld_words_o
);

  localparam int Depth = 2 ** ADDR_W;

  ld_state_t state, state_n;

  logic [`InstBus]   mem [Depth];
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   words;
  logic              err;
  logic              accept;
  logic              full;
  logic              word_valid;
  logic [`InstBus]   word;
  logic              wr_en;
  logic              unused_addr;

  assign ld_ready_o = (state == LD_LOAD);
  assign cpu_hold_o = (state == LD_LOAD) | (state == LD_DONE);
  assign ld_done_o  = (state == LD_DONE);
  assign ld_err_o   = err;
  assign ld_words_o = words;

  // a restart wins over a byte offered in the same cycle
  assign accept = ld_valid_i & ld_ready_o & ~ld_start_i;
  assign full   = words[ADDR_W];
  assign wr_en  = word_valid & ~full;

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (ld_start_i),
    .in_valid   (accept),
    .in_byte    (ld_byte_i),
    .in_last    (ld_last_i),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      LD_IDLE: begin
        if (ld_start_i) state_n = LD_LOAD;
      end
      LD_LOAD: begin
        if (ld_start_i)
          state_n = LD_LOAD;
        else if (accept & ld_last_i)
          state_n = LD_DONE;
      end
      LD_DONE: begin
        state_n = ld_start_i ? LD_LOAD : LD_IDLE;
      end
      default: state_n = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LD_IDLE;
      ptr   <= '0;
      words <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      if (ld_start_i) begin
        ptr   <= '0;
        words <= '0;
        err   <= 1'b0;
      end else if (accept) begin
        if (full) begin
          err <= 1'b1;
        end else if (word_valid) begin
          ptr   <= ptr + ADDR_W'(1);
          words <= words + (ADDR_W+1)'(1);
        end
      end
    end
  end

  // array is not reset: contents survive a CPU/system reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr] <= word;
  end

  assign rom_data_o = rom_ce_i ? mem[rom_addr_i[ADDR_W+1:2]] : '0;

  assign unused_addr = ^{rom_addr_i[31:ADDR_W+2], rom_addr_i[1:0]};

endmodule

// File: tb/tb_inst_mem.sv
// Directed bench for inst_mem (4-word instance) with a
// byte-queue reference model checked every cycle.
module tb_inst_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        ld_start_i;
  logic        ld_valid_i;
  logic [7:0]  ld_byte_i;
  logic        ld_last_i;
  logic        ld_ready_o;
  logic        cpu_hold_o;
  logic        ld_done_o;
  logic        ld_err_o;
  logic [2:0]  ld_words_o;

  inst_mem #(.ADDR_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce_i),
    .rom_addr_i (rom_addr_i),
    .rom_data_o (rom_data_o),
    .ld_start_i (ld_start_i),
    .ld_valid_i (ld_valid_i),
    .ld_byte_i  (ld_byte_i),
    .ld_last_i  (ld_last_i),
    .ld_ready_o (ld_ready_o),
    .cpu_hold_o (cpu_hold_o),
    .ld_done_o  (ld_done_o),
    .ld_err_o   (ld_err_o),
    .ld_words_o (ld_words_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference model: image bytes collected per word, memory as an array
  bit          m_loading = 1'b0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  int          m_words = 0;
  logic [7:0]  q[$];
  logic [31:0] m_mem[4];
  bit          m_known[4];
  logic [31:0] mw;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_loading = 1'b0;
      m_done = 1'b0;
      m_err = 1'b0;
      m_words = 0;
      q.delete();
    end else begin
      m_done = 1'b0;
      if (ld_start_i) begin
        m_loading = 1'b1;
        m_err = 1'b0;
        m_words = 0;
        q.delete();
      end else if (m_loading && ld_valid_i) begin
        if (m_words == 4) begin
          m_err = 1'b1;
        end else begin
          q.push_back(ld_byte_i);
          if (q.size() == 4 || ld_last_i) begin
            mw = 32'h0;
            foreach (q[i]) mw = mw | ({q[i], 24'h0} >> (8 * i));
            m_mem[m_words] = mw;
            m_known[m_words] = 1'b1;
            m_words++;
            q.delete();
          end
        end
        if (ld_last_i) begin
          m_loading = 1'b0;
          m_done = 1'b1;
          q.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ld_done_o) done_cnt++;
    if (chk_en) begin
      chk("ready", 32'(ld_ready_o), 32'(m_loading));
      chk("hold", 32'(cpu_hold_o), 32'(m_loading | m_done));
      chk("done", 32'(ld_done_o), 32'(m_done));
      chk("err", 32'(ld_err_o), 32'(m_err));
      chk("words", 32'(ld_words_o), 32'(m_words));
      if (!rom_ce_i)
        chk("fetch_off", rom_data_o, 32'h0);
      else if (m_known[rom_addr_i[3:2]])
        chk("fetch", rom_data_o, m_mem[rom_addr_i[3:2]]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    ld_start_i = 1'b1;
    tick();
    ld_start_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit last);
    ld_valid_i = 1'b1;
    ld_byte_i  = b;
    ld_last_i  = last;
    tick();
    ld_valid_i = 1'b0;
    ld_last_i  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic ce);
    rom_addr_i = a;
    rom_ce_i   = ce;
    #1;
  endtask

  initial begin
    logic [7:0] img[8];
    ld_start_i = 1'b0;
    ld_valid_i = 1'b0;
    ld_byte_i  = 8'h0;
    ld_last_i  = 1'b0;
    rom_ce_i   = 1'b0;
    rom_addr_i = 32'h0;

    #3 rst = 1'b0;
    #5;
    chk("rst_ready", 32'(ld_ready_o), 32'h0);
    chk("rst_hold", 32'(cpu_hold_o), 32'h0);
    chk("rst_done", 32'(ld_done_o), 32'h0);
    chk("rst_err", 32'(ld_err_o), 32'h0);
    chk("rst_words", 32'(ld_words_o), 32'h0);
    tick();
    rst = 1'b1;
    chk_en = 1'b1;
    tick();

    // two full words
    img = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAB, 8'hCD, 8'hEF, 8'h01};
    start();
    chk("t1_hold_up", 32'(cpu_hold_o), 32'h1);
    foreach (img[i]) send(img[i], i == 7);
    chk("t1_done", 32'(ld_done_o), 32'h1);
    chk("t1_hold_done", 32'(cpu_hold_o), 32'h1);
    tick();
    chk("t1_hold_fall", 32'(cpu_hold_o), 32'h0);
    chk("t1_words", 32'(ld_words_o), 32'h2);
    fetch(32'h0, 1'b1);
    chk("t1_mem0", rom_data_o, 32'h12345678);
    fetch(32'h4, 1'b1);
    chk("t1_mem1", rom_data_o, 32'hABCDEF01);
    chk("t1_done_cnt", 32'(done_cnt), 32'h1);
    fetch(32'h0, 1'b0);
    tick();

    // partial final word padded with zeros
    start();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    send(8'h55, 1'b1);
    tick();
    chk("t2_words", 32'(ld_words_o), 32'h2);
    fetch(32'h4, 1'b1);
    chk("t2_pad", rom_data_o, 32'h55000000);
    fetch(32'h7, 1'b1);
    chk("t2_lowbits", rom_data_o, 32'h55000000);
    fetch(32'h14, 1'b1);
    chk("t2_alias", rom_data_o, 32'h55000000);
    fetch(32'h4, 1'b0);
    chk("t2_ce_off", rom_data_o, 32'h0);
    tick();

    // overflow past 4 words
    start();
    for (int i = 0; i < 20; i++) send(8'(8'h80 + i), i == 19);
    chk("t3_done", 32'(ld_done_o), 32'h1);
    chk("t3_err", 32'(ld_err_o), 32'h1);
    chk("t3_words", 32'(ld_words_o), 32'h4);
    tick();
    chk("t3_err_sticky", 32'(ld_err_o), 32'h1);
    fetch(32'h0, 1'b1);
    chk("t3_mem0", rom_data_o, 32'h80818283);
    fetch(32'hC, 1'b1);
    chk("t3_mem3", rom_data_o, 32'h8C8D8E8F);
    chk("t3_done_cnt", 32'(done_cnt), 32'h3);
    fetch(32'h0, 1'b0);
    tick();

    // restart drops the partial word and a same-cycle byte
    start();
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b0);
    ld_start_i = 1'b1;
    ld_valid_i = 1'b1;
    ld_byte_i  = 8'h77;
    tick();
    ld_start_i = 1'b0;
    ld_valid_i = 1'b0;
    chk("t4_err_clr", 32'(ld_err_o), 32'h0);
    send(8'hDE, 1'b0);
    send(8'hAD, 1'b0);
    send(8'hBE, 1'b0);
    send(8'hEF, 1'b1);
    tick();
    chk("t4_words", 32'(ld_words_o), 32'h1);
    fetch(32'h0, 1'b1);
    chk("t4_mem0", rom_data_o, 32'hDEADBEEF);
    fetch(32'h4, 1'b1);
    chk("t4_mem1_kept", rom_data_o, 32'h84858687);
    fetch(32'h0, 1'b0);
    tick();

    // asynchronous reset mid-load
    start();
    for (int i = 1; i <= 6; i++) send(8'(i), 1'b0);
    rst = 1'b0;
    #1;
    chk("t5_ready", 32'(ld_ready_o), 32'h0);
    chk("t5_hold", 32'(cpu_hold_o), 32'h0);
    chk("t5_words", 32'(ld_words_o), 32'h0);
    tick();
    rst = 1'b1;
    tick();
    fetch(32'h0, 1'b1);
    chk("t5_mem0", rom_data_o, 32'h01020304);
    fetch(32'h4, 1'b1);
    chk("t5_mem1", rom_data_o, 32'h84858687);
    fetch(32'h0, 1'b0);
    tick();

    // read and write of the same word in one cycle
    start();
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    send(8'hA3, 1'b0);
    rom_ce_i   = 1'b1;
    rom_addr_i = 32'h0;
    ld_valid_i = 1'b1;
    ld_byte_i  = 8'hA4;
    ld_last_i  = 1'b1;
    #2;
    chk("t6_old", rom_data_o, 32'h01020304);
    tick();
    ld_valid_i = 1'b0;
    ld_last_i  = 1'b0;
    chk("t6_new", rom_data_o, 32'hA1A2A3A4);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
